lut_function_unit: RTL
======================

# lut_function_unit

Programmable N-input Boolean function unit with a registered output. It replaces fixed-logic 4-input function circuits: the function is held as a 2^N-bit truth table, loaded serially through a ready/valid port. A built-in sweep mode walks every input combination and streams the results out, so a bench or on-chip checker can read back the whole function without driving the inputs itself.

## Interface
Parameters:
- `N`, default 4: number of function inputs; legal range 2..8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  evaluation enable. When low, the unit evaluates nothing and a sweep pauses.
- `in`  in  N  function inputs; `in[0]` is the LSB of the table index.
- `cfg_start`  in  1  one-cycle request to begin loading a new truth table.
- `cfg_valid`  in  1  `cfg_bit` is valid this cycle.
- `cfg_bit`  in  1  serial truth-table bit, sent index 0 first.
- `cfg_ready`  out  1  high while the LOAD state can accept a bit.
- `cfg_done`  out  1  one-cycle pulse when the new table is committed.
- `sweep_start`  in  1  one-cycle request to begin an exhaustive sweep.
- `sweep_idx`  out  N  table index that produced the current `f` during a sweep.
- `sweep_done`  out  1  one-cycle pulse with the last sweep result.
- `f`  out  1  registered function output.
- `f_valid`  out  1  `f` holds a fresh result this cycle.

## Operation
- Storage:
  - active table `tbl[2^N-1:0]`; shadow table `shd[2^N-1:0]`; bit counter `cnt` of N+1 bits.
  - Reset clears both tables, so the function is constant 0.
- States: RUN (reset state), LOAD, SWEEP.
- RUN:
  - if `en` is high: `f <= tbl[in]`, `f_valid <= 1`.
  - if `en` is low: `f <= 0`, `f_valid <= 0`.
  - `cfg_start` goes to LOAD with `cnt <= 0`.
  - `sweep_start` goes to SWEEP with the index cleared to 0.
  - `cfg_start` has priority when both arrive in the same cycle; `sweep_start` is then ignored.
- LOAD:
  - `cfg_ready` = 1.
  - Each cycle with `cfg_valid` high: `shd[cnt] <= cfg_bit`, `cnt++`.
  - On the 2^N-th accepted bit: `tbl <= shd` with the final bit merged in, `cfg_done` pulses for one cycle, state returns to RUN.
  - `f` holds its last value; `f_valid` = 0.
  - `cfg_start` during LOAD restarts the load: `cnt <= 0` and the partial shadow contents are discarded. This takes priority over a `cfg_valid` in the same cycle.
  - `sweep_start` and `en` are ignored.
- SWEEP:
  - `in` is ignored.
  - Each cycle with `en` high: `f <= tbl[idx]`, `sweep_idx <= idx`, `f_valid <= 1`, `idx++`.
  - When `idx = 2^N-1` is emitted: `sweep_done` pulses with that result and state returns to RUN. The index does not wrap.
  - If `en` is low: the index holds, `f_valid` = 0, `f` holds.
  - `cfg_start` aborts the sweep and goes to LOAD. No `sweep_done` is produced.
  - `sweep_start` during SWEEP is ignored.
- Reset asserted at any time, including mid-load or mid-sweep:
  - state goes to RUN, tables clear, `cnt` and index go to 0.
  - `f`, `f_valid`, `cfg_done`, `sweep_done`, `sweep_idx` go to 0; `cfg_ready` goes to 0.
- A partial load never changes `tbl`; the commit is atomic.

## Timing
- Evaluation latency is 1 cycle: `in` sampled at edge k appears on `f` after edge k.
- Load takes exactly 2^N accepted bits. With `cfg_valid` held high, `cfg_done` follows `cfg_start` by 2^N+1 cycles:
  - first bit accepted on the edge after the start edge;
  - `cfg_done` is registered with the commit edge;
  - the first RUN evaluation using the new table occurs on the edge after `cfg_done`.
- `cfg_ready` is a registered function of state only; it is high from the cycle after `cfg_start` until the commit.
- Sweep with `en` held high: 2^N consecutive `f_valid` cycles, starting 1 cycle after `sweep_start`, in order idx 0..2^N-1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset, then `en`=1 and drive all 16 `in` values (N=4) → `f`=0 and `f_valid`=1 one cycle after each value.
- Load 0x6996 (parity), `cfg_valid` held high → `cfg_done` 17 cycles after `cfg_start`. Then `in`=4'b0111 → `f`=1; `in`=4'b0011 → `f`=0.
- Load 0x8000 with `cfg_valid` gaps inserted, then sweep with `en` toggling → 16 `f_valid` beats; `f`=1 only at `sweep_idx`=15; `sweep_done` on the idx-15 beat.
- Load 0x6996, start a load of 0xFFFF, assert `rst_n` low after 7 bits → all outputs 0; afterwards `in`=4'b0001 gives `f`=0 (table cleared, not partially loaded).
- Assert `cfg_start` and `sweep_start` in the same cycle → LOAD entered, `cfg_ready`=1, no sweep beats. Then `cfg_start` again after 5 bits → exactly 16 further bits are needed before `cfg_done`.
- `en`=0 in RUN with table 0xFFFF → `f`=0 and `f_valid`=0. Raising `en` → `f`=1 after 1 cycle.

Source files
------------

// File: rtl/lut_function_unit.sv
// Programmable N-input Boolean function unit.
// The function is a 2^N-entry truth table. New tables arrive one bit at a time
// into a shadow copy and replace the active table in a single commit. A sweep
// mode reads the active table out in index order, one entry per enabled cycle.
//
// Config handshake: a bit is accepted on a rising edge where cfg_ready and
// cfg_valid are both high. cfg_ready is registered and depends only on the
// state. cfg_start restarts the load and wins over a cfg_valid in the same
// cycle. There is no backpressure on f / f_valid / sweep_done.
module lut_function_unit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] in,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_ready,
  output logic         cfg_done,
  input  logic         sweep_start,
  output logic [N-1:0] sweep_idx,
  output logic         sweep_done,
  output logic         f,
  output logic         f_valid
);

  localparam int DEPTH = 1 << N;
  localparam logic [N:0] LAST_CNT = (N+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly.
  state_t state;
  state_t state_next;

  logic [DEPTH-1:0] tbl;
  logic [DEPTH-1:0] shd;
  logic [DEPTH-1:0] shd_merged;
  logic [N:0]       cnt;
  logic [N-1:0]     idx;
  logic             load_last;
  logic             sweep_last;

  assign load_last  = cfg_valid && (cnt == LAST_CNT);
  assign sweep_last = en && (idx == {N{1'b1}});

  // Shadow table with the bit arriving this cycle merged in, so the commit
  // includes the final bit without an extra cycle.
  always_comb begin
    shd_merged = shd;
    shd_merged[cnt[N-1:0]] = cfg_bit;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; cfg_start wins in every state.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (cfg_start)        state_next = ST_LOAD;
        else if (sweep_start) state_next = ST_SWEEP;
      end
      ST_LOAD: begin
        if (cfg_start)      state_next = ST_LOAD;
        else if (load_last) state_next = ST_RUN;
      end
      ST_SWEEP: begin
        if (cfg_start)       state_next = ST_LOAD;
        else if (sweep_last) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Datapath: tables, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl        <= '0;
      shd        <= '0;
      cnt        <= '0;
      idx        <= '0;
      f          <= 1'b0;
      f_valid    <= 1'b0;
      cfg_ready  <= 1'b0;
      cfg_done   <= 1'b0;
      sweep_done <= 1'b0;
      sweep_idx  <= '0;
    end else begin
      cfg_done   <= 1'b0;
      sweep_done <= 1'b0;
      cfg_ready  <= (state_next == ST_LOAD);
      case (state)
        ST_RUN: begin
          if (en) begin
            f       <= tbl[in];
            f_valid <= 1'b1;
          end else begin
            f       <= 1'b0;
            f_valid <= 1'b0;
          end
          if (cfg_start) begin
            cnt <= '0;
            shd <= '0;
          end else if (sweep_start) begin
            idx <= '0;
          end
        end
        ST_LOAD: begin
          f_valid <= 1'b0;
          if (cfg_start) begin
            cnt <= '0;
            shd <= '0;
          end else if (cfg_valid) begin
            shd[cnt[N-1:0]] <= cfg_bit;
            if (cnt == LAST_CNT) begin
              tbl      <= shd_merged;
              cfg_done <= 1'b1;
              cnt      <= '0;
            end else begin
              cnt <= cnt + (N+1)'(1);
            end
          end
        end
        ST_SWEEP: begin
          if (cfg_start) begin
            f_valid <= 1'b0;
            cnt     <= '0;
            shd     <= '0;
          end else if (en) begin
            f          <= tbl[idx];
            sweep_idx  <= idx;
            f_valid    <= 1'b1;
            sweep_done <= sweep_last;
            if (!sweep_last) idx <= idx + N'(1);
          end else begin
            f_valid <= 1'b0;
          end
        end
        default: begin
          f_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
